// File: rtl/seq_det_defs.sv
// Shared definitions for the serial pattern detector: FSM encoding and default pattern.
`default_nettype none

package seq_det_defs;
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } det_state_e;

  localparam logic [3:0] DEF_PAT = 4'b1011;
endpackage

`default_nettype wire

// File: rtl/seq_detector_param_if.sv
// Bus bundle between the pattern-detector core and its user.
`default_nettype none

interface seq_detector_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             x;
  logic             x_valid;
  logic [PAT_W-1:0] pat_in;
  logic             pat_load;
  logic             overlap;
  logic             F;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output x, x_valid, pat_in, pat_load, overlap,
    input  F, match_cnt, cnt_sat
  );

  modport slave (
    input  x, x_valid, pat_in, pat_load, overlap,
    output F, match_cnt, cnt_sat
  );
endinterface

`default_nettype wire

// File: rtl/seq_shift_hist.sv
// History shift register of the last PAT_W-1 accepted bits plus fill tracking.
`default_nettype none

module seq_shift_hist #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             din,
  output logic [PAT_W-2:0] hist,
  output logic             full,
  output logic             near_full
);
  localparam int            FW        = $clog2(PAT_W);
  localparam logic [FW-1:0] FILL_MAX  = FW'(PAT_W - 1);
  localparam logic [FW-1:0] FILL_NEAR = FW'(PAT_W - 2);

  logic [FW-1:0]    fill;
  logic [PAT_W-2:0] hist_nxt;

  // A two-bit pattern keeps a single history bit, so there is nothing to shift along.
  if (PAT_W > 2) begin : g_wide
    assign hist_nxt = {hist[PAT_W-3:0], din};
  end else begin : g_narrow
    assign hist_nxt = din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_nxt;
      if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

  assign full      = (fill == FILL_MAX);
  assign near_full = (fill == FILL_NEAR);
endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap select, match pulse and saturating counter.
`default_nettype none

module seq_detector_param
  import seq_det_defs::*;
#(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_PAT)
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);
  det_state_e       state;
  det_state_e       state_nxt;
  logic [PAT_W-1:0] pat_reg;
  logic [PAT_W-2:0] hist;
  logic             full;
  logic             near_full;
  logic [PAT_W-1:0] cand;
  logic             accept;
  logic             match;
  logic             hist_clr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             f_reg;
  logic             sat_reg;

  seq_shift_hist #(
    .PAT_W (PAT_W)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (accept),
    .clr       (hist_clr),
    .din       (bus.x),
    .hist      (hist),
    .full      (full),
    .near_full (near_full)
  );

  always_comb begin
    accept   = bus.x_valid && !bus.pat_load;
    cand     = {hist, bus.x};
    match    = accept && (state == ST_ARMED) && (cand == pat_reg);
    hist_clr = bus.pat_load || (match && !bus.overlap);
    cnt_nxt  = cnt;
    if (match && !(&cnt)) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.pat_load) begin
      state_nxt = ST_FILL;
    end else if (accept) begin
      // A non-overlapping match discards the history, so the window must refill.
      if (match && !bus.overlap) begin
        state_nxt = ST_FILL;
      end else if (full || near_full) begin
        state_nxt = ST_ARMED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_FILL;
      pat_reg <= RST_PAT;
      f_reg   <= 1'b0;
      cnt     <= '0;
      sat_reg <= 1'b0;
    end else begin
      state   <= state_nxt;
      f_reg   <= match;
      cnt     <= cnt_nxt;
      sat_reg <= sat_reg || (&cnt_nxt);
      if (bus.pat_load) begin
        pat_reg <= bus.pat_in;
      end
    end
  end

  assign bus.F         = f_reg;
  assign bus.match_cnt = cnt;
  assign bus.cnt_sat   = sat_reg;
endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: a wide-counter and a 2-bit-counter detector share one directed stimulus stream.
`default_nettype none

module tb_seq_detector_param;
  logic clk = 1'b0;
  logic rst = 1'b0;

  seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) bus_a ();
  seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) bus_s ();

  seq_detector_param #(.PAT_W(4), .CNT_W(8), .RST_PAT(4'b1011)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(2), .RST_PAT(4'b1011)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int  tag;
    bit  which;
    bit  f;
    int  cnt;
    bit  sat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_n  = 0;

  task automatic chk(input string name, input int tag, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s step %0d actual=%0d required=%0d", name, tag, act, req);
    end
  endtask

  // Outputs become valid after the edge that consumed a vector; compare on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (!e.which) begin
        chk("F_a",   e.tag, int'(bus_a.F),         int'(e.f));
        chk("cnt_a", e.tag, int'(bus_a.match_cnt), e.cnt);
        chk("sat_a", e.tag, int'(bus_a.cnt_sat),   int'(e.sat));
      end else begin
        chk("F_s",   e.tag, int'(bus_s.F),         int'(e.f));
        chk("cnt_s", e.tag, int'(bus_s.match_cnt), e.cnt);
        chk("sat_s", e.tag, int'(bus_s.cnt_sat),   int'(e.sat));
      end
    end
  end

  task automatic drive(input bit v, input bit xb, input bit ld, input logic [3:0] pin, input bit ov);
    bus_a.x_valid = v;  bus_s.x_valid = v;
    bus_a.x = xb;       bus_s.x = xb;
    bus_a.pat_load = ld; bus_s.pat_load = ld;
    bus_a.pat_in = pin; bus_s.pat_in = pin;
    bus_a.overlap = ov; bus_s.overlap = ov;
  endtask

  task automatic step(input bit v, input bit xb, input bit ld, input logic [3:0] pin, input bit ov,
                      input bit which, input bit ef, input int ecnt, input bit esat);
    exp_t e;
    @(negedge clk);
    drive(v, xb, ld, pin, ov);
    @(posedge clk);
    tag_n++;
    e.tag = tag_n; e.which = which; e.f = ef; e.cnt = ecnt; e.sat = esat;
    q.push_back(e);
  endtask

  task automatic check_reset_outputs(input int tag);
    chk("rst_F_a",   tag, int'(bus_a.F),         0);
    chk("rst_cnt_a", tag, int'(bus_a.match_cnt), 0);
    chk("rst_sat_a", tag, int'(bus_a.cnt_sat),   0);
    chk("rst_F_s",   tag, int'(bus_s.F),         0);
    chk("rst_cnt_s", tag, int'(bus_s.match_cnt), 0);
    chk("rst_sat_s", tag, int'(bus_s.cnt_sat),   0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    #1;
    check_reset_outputs(0);
    @(negedge clk);
    rst = 1'b1;

    // Overlapping detection of 1011 in 1,0,1,1,0,1,1
    step(1, 1, 0, 4'h0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 4'h0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 4'h0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 4'h0, 1, 0, 1, 1, 0);
    step(1, 0, 0, 4'h0, 1, 0, 0, 1, 0);
    step(1, 1, 0, 4'h0, 1, 0, 0, 1, 0);
    step(1, 1, 0, 4'h0, 1, 0, 1, 2, 0);

    // Pulse reset mid-cycle while F=1 and match_cnt=2
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    #1 rst = 1'b0;
    #1 check_reset_outputs(100);
    #1 rst = 1'b1;

    // Partial pattern after reset must not fire; completing it does
    step(1, 1, 0, 4'h0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 4'h0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 4'h0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 4'h0, 1, 0, 1, 1, 0);

    // Flush history via reload of the same pattern, then non-overlapping detection
    step(1, 1, 1, 4'b1011, 0, 0, 0, 1, 0);
    step(1, 1, 0, 4'h0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 4'h0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 4'h0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 4'h0, 0, 0, 1, 2, 0);
    step(1, 0, 0, 4'h0, 0, 0, 0, 2, 0);
    step(1, 1, 0, 4'h0, 0, 0, 0, 2, 0);
    step(1, 1, 0, 4'h0, 0, 0, 0, 2, 0);
    step(1, 1, 0, 4'h0, 0, 0, 0, 2, 0);
    step(1, 0, 0, 4'h0, 0, 0, 0, 2, 0);
    step(1, 1, 0, 4'h0, 0, 0, 0, 2, 0);
    step(1, 1, 0, 4'h0, 0, 0, 1, 3, 0);

    // Gapped input: invalid cycles carry x=1 that must be ignored
    step(1, 1, 0, 4'h0, 1, 0, 0, 3, 0);
    step(1, 0, 0, 4'h0, 1, 0, 0, 3, 0);
    step(0, 1, 0, 4'h0, 1, 0, 0, 3, 0);
    step(0, 1, 0, 4'h0, 1, 0, 0, 3, 0);
    step(0, 0, 0, 4'h0, 1, 0, 0, 3, 0);
    step(1, 1, 0, 4'h0, 1, 0, 0, 3, 0);
    step(1, 1, 0, 4'h0, 1, 0, 1, 4, 0);

    // Reload to 0110 mid-stream; the load-cycle bit is dropped and 1011 no longer matches
    step(1, 1, 0, 4'h0, 1, 0, 0, 4, 0);
    step(1, 0, 0, 4'h0, 1, 0, 0, 4, 0);
    step(1, 1, 0, 4'h0, 1, 0, 0, 4, 0);
    step(1, 1, 1, 4'b0110, 1, 0, 0, 4, 0);
    step(1, 0, 0, 4'h0, 1, 0, 0, 4, 0);
    step(1, 1, 0, 4'h0, 1, 0, 0, 4, 0);
    step(1, 1, 0, 4'h0, 1, 0, 0, 4, 0);
    step(1, 0, 0, 4'h0, 1, 0, 1, 5, 0);
    step(1, 1, 0, 4'h0, 1, 0, 0, 5, 0);
    step(1, 1, 0, 4'h0, 1, 0, 0, 5, 0);

    // Full reset restores 1011, then saturate the 2-bit counter
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    #1 check_reset_outputs(200);
    @(negedge clk);
    rst = 1'b1;
    for (int g = 1; g <= 5; g++) begin
      int  c;
      bit  s;
      c = (g < 3) ? g : 3;
      s = (g >= 3);
      step(1, 1, 0, 4'h0, 0, 1, 0, c - 1 + ((g > 3) ? 1 : 0), (g > 3));
      step(1, 0, 0, 4'h0, 0, 1, 0, c - 1 + ((g > 3) ? 1 : 0), (g > 3));
      step(1, 1, 0, 4'h0, 0, 1, 0, c - 1 + ((g > 3) ? 1 : 0), (g > 3));
      step(1, 1, 0, 4'h0, 0, 1, 1, c, s);
    end

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 999, q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector: the next generation of the team's single-bit Moore/Mealy sequence machines.
- Samples a 1-bit stream (qualified by x_valid) and compares it against a runtime-loadable PAT_W-bit pattern.
- Selectable overlapping or non-overlapping detection.
- Emits a registered one-cycle match pulse F and keeps a saturating match counter for status readback.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..16).
- CNT_W, 8, width of the match counter.
- RST_PAT, 4'b1011 (PAT_W bits), pattern value loaded by reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- x  input  1  serial data bit.
- x_valid  input  1  x is sampled only on edges where x_valid=1.
- pat_in  input  PAT_W  new pattern; first-received bit is MSB.
- pat_load  input  1  captures pat_in on the edge; synchronous.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every edge.
- F  output  1  registered match pulse.
- match_cnt  output  CNT_W  number of matches since reset, saturating.
- cnt_sat  output  1  high once match_cnt has reached its maximum value.

Behaviour:
- Reset (rst=0, asynchronous):
  - hist=0, fill=0, state=FILL, pat_reg=RST_PAT.
  - F=0, match_cnt=0, cnt_sat=0.
  - Outputs are forced low immediately, without waiting for a clock edge.
- Internal state: hist = last PAT_W-1 accepted bits; fill = number of valid bits held, 0..PAT_W-1.
- States:
  - FILL: fill < PAT_W-1.
  - ARMED: fill = PAT_W-1.
  - Advance on an accepted bit: FILL→ARMED when fill reaches PAT_W-1.
  - On a match with overlap=0: ARMED→FILL.
- Accepted bit (x_valid=1, pat_load=0): cand = {hist, x}.
  - match = (state==ARMED) && (cand == pat_reg).
  - A partially filled history must never match.
- On match:
  - F=1 for exactly the next cycle.
  - match_cnt increments unless already all-ones.
  - cnt_sat=1 when the post-update count is all-ones; stays high until reset.
- History update after an accepted bit:
  - No match, or match with overlap=1: hist ← cand[PAT_W-2:0]; fill ← min(fill+1, PAT_W-1).
  - Match with overlap=0: hist ← 0, fill ← 0 (the next match needs PAT_W fresh bits).
- x_valid=0: hist, fill and state hold; F=0 on the following cycle.
- Latency: F is high in the clock cycle following the edge that sampled the completing bit. No combinational path from x to F.
- pat_load=1:
  - pat_reg ← pat_in; hist, fill ← 0; state ← FILL; F ← 0.
  - The bit presented on that edge is discarded even if x_valid=1.
  - match_cnt and cnt_sat are unchanged.
- Changing overlap mid-stream takes effect on the next accepted bit; no flush.
- All-zero or all-one patterns are legal. With overlap=1, a constant stream gives F=1 on every accepted bit once ARMED.
- rst asserted mid-stream: everything returns to reset values, including pat_reg=RST_PAT.
- Width rules: match_cnt is unsigned and never wraps. fill width is $clog2(PAT_W).

Decomposition:
- Shared package/header seq_det_defs:
  - State encodings ST_FILL=1'b0, ST_ARMED=1'b1.
  - Default pattern constant used for RST_PAT.
- One natural sub-module: seq_shift_hist.
  - Contains the PAT_W-1 history shift register and fill counter.
  - Has shift-enable and clear inputs; outputs hist and full.
- Match compare, FSM and counter stay in the top.

Test Plan:
Each scenario uses PAT_W=4, pat=1011, overlap=1, x_valid=1 unless stated.
- Overlap stream: x=1,0,1,1,0,1,1 → F high in the cycles after bits 4 and 7; match_cnt=2.
- Non-overlap: same stream with overlap=0 → F only after bit 4; match_cnt=1. Then feed 1,0,1,1 → second match; match_cnt=2.
- Gapped input: stream 1,0,1,1 with x_valid=0 for 3 cycles between bits 2 and 3 → single F after the 4th valid bit. F stays 0 during the gaps.
- Reload mid-stream: after 1,0,1, assert pat_load with pat_in=0110 and x=1 → that x is ignored. Then 0,1,1,0 → F after bit 4; the old pattern never matches; match_cnt preserved.
- Saturation (CNT_W=2): stream 1,0,1,1 repeated 5 times with overlap=0 → match_cnt is 1,2,3,3,3; cnt_sat rises with the third match; F still pulses on every match.
- Async reset: drive rst=0 for 2 ns mid-cycle while F=1 and match_cnt=2 → F, match_cnt and cnt_sat go 0 before the next edge. After release, stream 1,0,1 gives no F until the full pattern is seen again.
